// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: widths, reset constants and
// the EX->MEM bundle for the ex_mem register.
package ex_mem_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int DREG_W     = 64;
  localparam int STALL_W    = 6;
  localparam int CNT_W      = 2;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;

  typedef struct packed {
    logic                  wreg;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
    logic                  whilo;
    logic [REG_DATA_W-1:0] hi;
    logic [REG_DATA_W-1:0] lo;
  } mem_bus_t;

  localparam mem_bus_t MEM_NOP = '{
    wreg:  WRITE_DISABLE,
    waddr: NOP_REG_ADDR,
    wdata: ZERO_WORD,
    whilo: WRITE_DISABLE,
    hi:    ZERO_WORD,
    lo:    ZERO_WORD
  };

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_BUBBLE  = 2'd1,
    MODE_ADVANCE = 2'd2
  } ex_mem_mode_e;

endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline register with
// stall/flush handling and madd intermediate.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_wreg,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [REG_DATA_W-1:0] ex_wdata,
  input  logic                  ex_whilo,
  input  logic [REG_DATA_W-1:0] ex_hi,
  input  logic [REG_DATA_W-1:0] ex_lo,
  input  logic [DREG_W-1:0]     hilo_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic                  mem_wreg,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic [REG_DATA_W-1:0] mem_wdata,
  output logic                  mem_whilo,
  output logic [REG_DATA_W-1:0] mem_hi,
  output logic [REG_DATA_W-1:0] mem_lo,
  output logic [DREG_W-1:0]     hilo_o,
  output logic [CNT_W-1:0]      cnt_o
);

  mem_bus_t          r_mem;
  logic [DREG_W-1:0] r_hilo;
  logic [CNT_W-1:0]  r_cnt;

  mem_bus_t     w_ex;
  ex_mem_mode_e w_mode;

  assign w_ex = '{
    wreg:  ex_wreg,
    waddr: ex_waddr,
    wdata: ex_wdata,
    whilo: ex_whilo,
    hi:    ex_hi,
    lo:    ex_lo
  };

  // Decode stall: EX running advances (even if
  // MEM is oddly stalled); EX-only stall bubbles.
  always_comb begin
    w_mode = MODE_HOLD;
    casez (stall)
      6'b??0???: w_mode = MODE_ADVANCE;
      6'b?01???: w_mode = MODE_BUBBLE;
      default:   w_mode = MODE_HOLD;
    endcase
  end

  // Register update: rst > flush > bubble > advance > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_mem  <= MEM_NOP;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_mem  <= MEM_NOP;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else begin
      unique case (w_mode)
        MODE_BUBBLE: begin
          r_mem  <= MEM_NOP;
          r_hilo <= hilo_i;
          r_cnt  <= cnt_i;
        end
        MODE_ADVANCE: begin
          r_mem  <= w_ex;
          r_hilo <= '0;
          r_cnt  <= '0;
        end
        default: begin
          r_mem  <= r_mem;
          r_hilo <= r_hilo;
          r_cnt  <= r_cnt;
        end
      endcase
    end
  end

  assign mem_wreg  = r_mem.wreg;
  assign mem_waddr = r_mem.waddr;
  assign mem_wdata = r_mem.wdata;
  assign mem_whilo = r_mem.whilo;
  assign mem_hi    = r_mem.hi;
  assign mem_lo    = r_mem.lo;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed checks of the ex_mem
// pipeline register.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  logic [168:0] exp_all;
  wire  [168:0] w_all = {mem_wreg, mem_waddr,
    mem_wdata, mem_whilo, mem_hi, mem_lo,
    hilo_o, cnt_o};

  always #5 clk = ~clk;

  ex_mem dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .ex_wreg  (ex_wreg),
    .ex_waddr (ex_waddr),
    .ex_wdata (ex_wdata),
    .ex_whilo (ex_whilo),
    .ex_hi    (ex_hi),
    .ex_lo    (ex_lo),
    .hilo_i   (hilo_i),
    .cnt_i    (cnt_i),
    .mem_wreg (mem_wreg),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo),
    .mem_hi   (mem_hi),
    .mem_lo   (mem_lo),
    .hilo_o   (hilo_o),
    .cnt_o    (cnt_o)
  );

  // The controller never releases EX while MEM stalls.
  always @(posedge clk)
    if (!rst)
      assert (!(!stall[3] && stall[4]))
        else $error("illegal stall vector %b", stall);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(
    input logic        wr,
    input logic [4:0]  a,
    input logic [31:0] d,
    input logic        wh,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    ex_wreg  = wr;
    ex_waddr = a;
    ex_wdata = d;
    ex_whilo = wh;
    ex_hi    = hi;
    ex_lo    = lo;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    flush  = 1'b0;
    stall  = 6'b000000;
    hilo_i = 64'hFFFF_0000_FFFF_0000;
    cnt_i  = 2'd3;
    drive_ex(1'b1, 5'd7, 32'h1234_5678,
             1'b1, 32'h1, 32'h2);
    tick();
    tick();
    checks++;
    if (w_all !== '0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0",
               w_all);
    end
    rst = 1'b0;
    tick();
    exp_all = {1'b1, 5'd7, 32'h1234_5678,
               1'b1, 32'h1, 32'h2, 64'h0, 2'd0};
    checks++;
    if (w_all !== exp_all) begin
      errors++;
      $display("FAIL reset_release got %h want %h",
               w_all, exp_all);
    end
    stall  = 6'b001111;
    cnt_i  = 2'd1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (w_all !== '0) begin
      errors++;
      $display("FAIL reset_async got %h want 0",
               w_all);
    end
    tick();
    rst   = 1'b0;
    stall = 6'b000000;
  endtask

  task automatic test_advance;
    hilo_i = 64'h0;
    cnt_i  = 2'd0;
    drive_ex(1'b1, 5'd3, 32'hDEAD_BEEF,
             1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if ({mem_wreg, mem_waddr, mem_wdata} !==
        {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL advance_gpr got %b %0d %h want 1 3 deadbeef",
               mem_wreg, mem_waddr, mem_wdata);
    end
    drive_ex(1'b0, 5'd31, 32'hFFFF_FFFF,
             1'b1, 32'hAAAA_5555, 32'h1234_5678);
    hilo_i = 64'h5;
    cnt_i  = 2'd2;
    tick();
    exp_all = {1'b0, 5'd31, 32'hFFFF_FFFF,
               1'b1, 32'hAAAA_5555, 32'h1234_5678,
               64'h0, 2'd0};
    checks++;
    if (w_all !== exp_all) begin
      errors++;
      $display("FAIL advance_b2b got %h want %h",
               w_all, exp_all);
    end
  endtask

  task automatic test_madd;
    stall  = 6'b001111;
    hilo_i = 64'h0000_0001_0000_0002;
    cnt_i  = 2'd1;
    drive_ex(1'b1, 5'd9, 32'h1111_1111,
             1'b1, 32'h3, 32'h4);
    tick();
    exp_all = {1'b0, 5'd0, 32'h0, 1'b0,
               32'h0, 32'h0,
               64'h0000_0001_0000_0002, 2'd1};
    checks++;
    if (w_all !== exp_all) begin
      errors++;
      $display("FAIL madd_bubble got %h want %h",
               w_all, exp_all);
    end
    stall  = 6'b000000;
    cnt_i  = 2'd2;
    hilo_i = 64'h0000_0009_0000_0009;
    drive_ex(1'b0, 5'd0, 32'h0,
             1'b1, 32'h5, 32'h7);
    tick();
    exp_all = {1'b0, 5'd0, 32'h0, 1'b1,
               32'h5, 32'h7, 64'h0, 2'd0};
    checks++;
    if (w_all !== exp_all) begin
      errors++;
      $display("FAIL madd_finish got %h want %h",
               w_all, exp_all);
    end
  endtask

  task automatic test_hold;
    stall = 6'b000000;
    drive_ex(1'b1, 5'd9, 32'h0BAD_F00D,
             1'b1, 32'h1111_2222, 32'h3333_4444);
    tick();
    exp_all = {1'b1, 5'd9, 32'h0BAD_F00D, 1'b1,
               32'h1111_2222, 32'h3333_4444,
               64'h0, 2'd0};
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      drive_ex(i[0], 5'(i + 20), 32'(i * 77),
               ~i[0], 32'(i), 32'(~i));
      hilo_i = 64'(i + 100);
      cnt_i  = 2'(i + 1);
      tick();
      checks++;
      if (w_all !== exp_all) begin
        errors++;
        $display("FAIL hold_mem[%0d] got %h want %h",
                 i, w_all, exp_all);
      end
    end
    stall  = 6'b001111;
    hilo_i = 64'hCAFE_0000_0000_BABE;
    cnt_i  = 2'd1;
    tick();
    exp_all = {1'b0, 5'd0, 32'h0, 1'b0,
               32'h0, 32'h0,
               64'hCAFE_0000_0000_BABE, 2'd1};
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      hilo_i = 64'(i + 200);
      cnt_i  = 2'(i + 2);
      drive_ex(1'b1, 5'd1, 32'(i), 1'b1,
               32'(i), 32'(i));
      tick();
      checks++;
      if (w_all !== exp_all) begin
        errors++;
        $display("FAIL hold_acc[%0d] got %h want %h",
                 i, w_all, exp_all);
      end
    end
  endtask

  task automatic test_flush;
    stall  = 6'b001111;
    hilo_i = 64'h0000_0001_0000_0002;
    cnt_i  = 2'd1;
    tick();
    flush  = 1'b1;
    hilo_i = 64'h1234_5678_9ABC_DEF0;
    cnt_i  = 2'd2;
    tick();
    checks++;
    if (w_all !== '0) begin
      errors++;
      $display("FAIL flush_bubble got %h want 0",
               w_all);
    end
    flush = 1'b0;
    stall = 6'b000000;
    drive_ex(1'b1, 5'd5, 32'h5555_AAAA,
             1'b1, 32'h9, 32'h8);
    tick();
    stall = 6'b011111;
    flush = 1'b1;
    tick();
    checks++;
    if (w_all !== '0) begin
      errors++;
      $display("FAIL flush_hold got %h want 0",
               w_all);
    end
    flush = 1'b0;
    stall = 6'b000000;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_madd();
    test_hold();
    test_flush();
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
